// File: rtl/sensor_scheduler.sv
// Shares one sensor decoder between buffered one-shot host requests and a periodic
// continuous-monitoring poll, with a per-job timeout and a held response port.
module sensor_scheduler #(
   parameter int POLL_PERIOD    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        host_valid,
   input  logic [7:0]  host_request,
   input  logic [31:0] host_device,
   output logic        host_ready,
   output logic        sd_enable,
   output logic [7:0]  sd_request,
   output logic [31:0] sd_device,
   input  logic        sd_finished,
   input  logic [7:0]  sd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_code,
   output logic [7:0]  rsp_data,
   output logic        cont_active
);

   localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [PW-1:0] POLL_ONE  = PW'(1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;

   localparam logic [7:0] CODE_START_T = 8'h03;
   localparam logic [7:0] CODE_START_H = 8'h04;
   localparam logic [7:0] CODE_STOP_T  = 8'h05;
   localparam logic [7:0] CODE_STOP_H  = 8'h06;
   localparam logic [7:0] CODE_TIMEOUT = 8'hFF;

   logic [1:0]    state_r;
   logic [7:0]    buf_code_r;
   logic [31:0]   buf_device_r;
   logic [7:0]    tag_r;
   logic [7:0]    cont_code_r;
   logic [31:0]   cont_device_r;
   logic          poll_pending_r;
   logic [PW-1:0] poll_cnt_r;
   logic [TW-1:0] tmo_cnt_r;

   logic          is_local_s;
   logic          take_host_s;
   logic          take_poll_s;
   logic          start_s;
   logic          stop_s;
   logic          poll_wrap_s;
   logic [7:0]    poll_code_s;

   // Dispatch decisions made from IDLE; a full host buffer always beats a pending poll.
   always_comb begin
      is_local_s  = 1'b0;
      poll_code_s = 8'h01;
      case (buf_code_r)
         CODE_START_T, CODE_START_H, CODE_STOP_T, CODE_STOP_H: is_local_s = 1'b1;
         default:                                             is_local_s = 1'b0;
      endcase
      take_host_s = (state_r == IDLE) && !host_ready;
      take_poll_s = (state_r == IDLE) && host_ready && poll_pending_r;
      start_s     = take_host_s && ((buf_code_r == CODE_START_T) || (buf_code_r == CODE_START_H));
      stop_s      = take_host_s &&
                    (((buf_code_r == CODE_STOP_T) && (cont_code_r == CODE_START_T)) ||
                     ((buf_code_r == CODE_STOP_H) && (cont_code_r == CODE_START_H)));
      poll_wrap_s = cont_active && (poll_cnt_r == POLL_LAST);
      if (cont_code_r == CODE_START_H) begin
         poll_code_s = 8'h02;
      end else begin
         poll_code_s = 8'h01;
      end
   end

   // One-entry host buffer; host_ready doubles as the "buffer empty" flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         host_ready   <= 1'b1;
         buf_code_r   <= 8'h00;
         buf_device_r <= 32'h0000_0000;
      end else if (take_host_s) begin
         host_ready <= 1'b1;
      end else if (host_valid && host_ready) begin
         host_ready   <= 1'b0;
         buf_code_r   <= host_request;
         buf_device_r <= host_device;
      end
   end

   // Continuous job registers and poll timer; a timer wrap outranks a poll dispatch clearing the flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cont_active    <= 1'b0;
         cont_code_r    <= 8'h00;
         cont_device_r  <= 32'h0000_0000;
         poll_pending_r <= 1'b0;
         poll_cnt_r     <= '0;
      end else if (start_s) begin
         cont_active    <= 1'b1;
         cont_code_r    <= buf_code_r;
         cont_device_r  <= buf_device_r;
         poll_pending_r <= 1'b1;
         poll_cnt_r     <= '0;
      end else if (stop_s) begin
         cont_active    <= 1'b0;
         poll_pending_r <= 1'b0;
         poll_cnt_r     <= '0;
      end else begin
         if (!cont_active || poll_wrap_s) begin
            poll_cnt_r <= '0;
         end else begin
            poll_cnt_r <= poll_cnt_r + POLL_ONE;
         end
         if (poll_wrap_s) begin
            poll_pending_r <= 1'b1;
         end else if (take_poll_s) begin
            poll_pending_r <= 1'b0;
         end
      end
   end

   // Job sequencer: issue to the decoder, supervise the timeout, hold the response until accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         tag_r      <= 8'h00;
         tmo_cnt_r  <= '0;
         sd_enable  <= 1'b0;
         sd_request <= 8'h00;
         sd_device  <= 32'h0000_0000;
         rsp_valid  <= 1'b0;
         rsp_code   <= 8'h00;
         rsp_data   <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (take_host_s && is_local_s) begin
                  rsp_code  <= buf_code_r;
                  rsp_data  <= 8'h00;
                  rsp_valid <= 1'b1;
                  state_r   <= RESPOND;
               end else if (take_host_s) begin
                  sd_request <= buf_code_r;
                  sd_device  <= buf_device_r;
                  tag_r      <= buf_code_r;
                  sd_enable  <= 1'b1;
                  tmo_cnt_r  <= '0;
                  state_r    <= BUSY;
               end else if (take_poll_s) begin
                  sd_request <= poll_code_s;
                  sd_device  <= cont_device_r;
                  tag_r      <= cont_code_r;
                  sd_enable  <= 1'b1;
                  tmo_cnt_r  <= '0;
                  state_r    <= BUSY;
               end
            end
            BUSY: begin
               if (sd_finished) begin
                  rsp_code  <= tag_r;
                  rsp_data  <= sd_data;
                  rsp_valid <= 1'b1;
                  sd_enable <= 1'b0;
                  state_r   <= RESPOND;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  rsp_code  <= CODE_TIMEOUT;
                  rsp_data  <= sd_request;
                  rsp_valid <= 1'b1;
                  sd_enable <= 1'b0;
                  state_r   <= RESPOND;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               sd_enable <= 1'b0;
               rsp_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with short poll/timeout periods and hand-computed expectations.
module tb_sensor_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        host_valid;
   logic [7:0]  host_request;
   logic [31:0] host_device;
   logic        host_ready;
   logic        sd_enable;
   logic [7:0]  sd_request;
   logic [31:0] sd_device;
   logic        sd_finished;
   logic [7:0]  sd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_code;
   logic [7:0]  rsp_data;
   logic        cont_active;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sensor_scheduler #(.POLL_PERIOD(100), .TIMEOUT_CYCLES(50)) dut (
      .clock(clock), .reset_n(reset_n),
      .host_valid(host_valid), .host_request(host_request), .host_device(host_device),
      .host_ready(host_ready),
      .sd_enable(sd_enable), .sd_request(sd_request), .sd_device(sd_device),
      .sd_finished(sd_finished), .sd_data(sd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_data(rsp_data),
      .cont_active(cont_active)
   );

   always #5 clock = ~clock;

   // Edge counter: at a negedge, cyc equals the number of rising edges seen so far.
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nxt(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send(input logic [7:0] code, input logic [31:0] dev);
      int k;
      k = 0;
      while (!host_ready && k < 300) begin
         nxt(1);
         k++;
      end
      check("send_ready", host_ready, 1'b1);
      host_valid   = 1'b1;
      host_request = code;
      host_device  = dev;
      nxt(1);
      host_valid   = 1'b0;
   endtask

   task automatic accept;
      rsp_ready = 1'b1;
      nxt(1);
      rsp_ready = 1'b0;
   endtask

   task automatic finish(input logic [7:0] d);
      sd_finished = 1'b1;
      sd_data     = d;
      nxt(1);
      sd_finished = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input logic [7:0] code, input logic [7:0] data);
      int k;
      k = 0;
      while (!rsp_valid && k < 300) begin
         nxt(1);
         k++;
      end
      check({tag, "_valid"}, rsp_valid, 1'b1);
      check({tag, "_code"}, rsp_code, code);
      check({tag, "_data"}, rsp_data, data);
   endtask

   task automatic wait_en(input string tag, output int at);
      int k;
      k = 0;
      while (!sd_enable && k < 300) begin
         nxt(1);
         k++;
      end
      check({tag, "_en"}, sd_enable, 1'b1);
      at = cyc;
   endtask

   initial begin
      int s;
      int t;
      int n;
      reset_n      = 1'b0;
      host_valid   = 1'b0;
      host_request = 8'h00;
      host_device  = 32'h0;
      sd_finished  = 1'b0;
      sd_data      = 8'h00;
      rsp_ready    = 1'b0;
      nxt(3);
      check("rst_ready", host_ready, 1'b1);
      check("rst_en", sd_enable, 1'b0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_cont", cont_active, 1'b0);
      check("rst_req", sd_request, 8'h00);
      check("rst_dev", sd_device, 32'h0);
      check("rst_code", rsp_code, 8'h00);
      check("rst_data", rsp_data, 8'h00);
      reset_n = 1'b1;
      nxt(2);

      // forwarded request with a stalled response port
      send(8'h01, 32'h0000_0001);
      check("fw_ready_low", host_ready, 1'b0);
      check("fw_en_early", sd_enable, 1'b0);
      nxt(1);
      check("fw_en", sd_enable, 1'b1);
      check("fw_req", sd_request, 8'h01);
      check("fw_dev", sd_device, 32'h0000_0001);
      check("fw_ready_back", host_ready, 1'b1);
      nxt(2);
      finish(8'h19);
      check("fw_en_off", sd_enable, 1'b0);
      wait_rsp("fw", 8'h01, 8'h19);
      for (int i = 0; i < 5; i++) begin
         nxt(1);
         check("fw_hold_valid", rsp_valid, 1'b1);
         check("fw_hold_data", {rsp_code, rsp_data}, 16'h0119);
      end
      accept;
      check("fw_released", rsp_valid, 1'b0);

      // timeout: decoder stays silent
      send(8'h10, 32'h0000_ABCD);
      nxt(1);
      n = 0;
      while (sd_enable && n < 200) begin
         n++;
         nxt(1);
      end
      check("tmo_len", n, 50);
      wait_rsp("tmo", 8'hFF, 8'h10);
      accept;

      // finish exactly on the terminal timeout cycle
      send(8'h20, 32'h0000_0002);
      nxt(1);
      check("term_en_start", sd_enable, 1'b1);
      nxt(49);
      check("term_en_last", sd_enable, 1'b1);
      finish(8'h5A);
      wait_rsp("term", 8'h20, 8'h5A);
      accept;

      // continuous temperature monitoring
      send(8'h03, 32'h0000_0077);
      nxt(1);
      s = cyc;
      wait_rsp("ack3", 8'h03, 8'h00);
      check("ack3_cont", cont_active, 1'b1);
      accept;
      check("ack3_released", rsp_valid, 1'b0);
      nxt(1);
      check("poll1_en", sd_enable, 1'b1);
      check("poll1_req", sd_request, 8'h01);
      check("poll1_dev", sd_device, 32'h0000_0077);
      finish(8'h1F);
      wait_rsp("poll1", 8'h03, 8'h1F);
      accept;
      wait_en("poll2", t);
      check("poll2_time", t, s + 101);
      check("poll2_req", sd_request, 8'h01);
      finish(8'h20);
      wait_rsp("poll2", 8'h03, 8'h20);
      accept;
      wait_en("poll3", t);
      check("poll3_time", t, s + 201);
      finish(8'h21);
      wait_rsp("poll3", 8'h03, 8'h21);
      accept;

      // stops: mismatched type is acknowledged but ignored
      send(8'h06, 32'h0);
      wait_rsp("stop6", 8'h06, 8'h00);
      check("stop6_cont", cont_active, 1'b1);
      accept;
      send(8'h05, 32'h0);
      wait_rsp("stop5", 8'h05, 8'h00);
      check("stop5_cont", cont_active, 1'b0);
      accept;
      n = 0;
      for (int i = 0; i < 250; i++) begin
         nxt(1);
         if (sd_enable) n++;
      end
      check("no_poll_after_stop", n, 0);

      // host request and poll wrap together, then one saturated poll over a long stall
      send(8'h04, 32'h0000_0055);
      nxt(1);
      s = cyc;
      wait_rsp("ack4", 8'h04, 8'h00);
      accept;
      nxt(1);
      check("hpoll1_req", sd_request, 8'h02);
      check("hpoll1_dev", sd_device, 32'h0000_0055);
      finish(8'h2A);
      wait_rsp("hpoll1", 8'h04, 8'h2A);
      accept;
      while (cyc < s + 99) nxt(1);
      send(8'h02, 32'h0000_0003);
      nxt(1);
      check("arb_host_en", sd_enable, 1'b1);
      check("arb_host_req", sd_request, 8'h02);
      check("arb_host_dev", sd_device, 32'h0000_0003);
      wait_rsp("arb_tmo", 8'hFF, 8'h02);
      while (cyc < s + 260) nxt(1);
      check("arb_held", rsp_valid, 1'b1);
      accept;
      wait_en("hpoll2", t);
      check("hpoll2_time", t, s + 262);
      check("hpoll2_req", sd_request, 8'h02);
      finish(8'h2B);
      wait_rsp("hpoll2", 8'h04, 8'h2B);
      accept;
      n = 0;
      while (cyc < s + 295) begin
         nxt(1);
         if (sd_enable) n++;
      end
      check("single_poll", n, 0);
      wait_en("hpoll3", t);
      check("hpoll3_time", t, s + 301);
      finish(8'h2C);
      wait_rsp("hpoll3", 8'h04, 8'h2C);
      accept;
      send(8'h06, 32'h0);
      wait_rsp("stop6h", 8'h06, 8'h00);
      check("stop6h_cont", cont_active, 1'b0);
      accept;

      // asynchronous reset mid-BUSY
      send(8'h30, 32'h0000_0004);
      nxt(2);
      check("rb_en", sd_enable, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("rb_en_off", sd_enable, 1'b0);
      check("rb_ready", host_ready, 1'b1);
      check("rb_req", sd_request, 8'h00);
      check("rb_dev", sd_device, 32'h0);
      nxt(1);
      reset_n = 1'b1;
      nxt(1);

      // asynchronous reset mid-RESPOND with monitoring active
      send(8'h03, 32'h0000_0009);
      nxt(1);
      check("rr_valid", rsp_valid, 1'b1);
      check("rr_cont", cont_active, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("rr_valid_off", rsp_valid, 1'b0);
      check("rr_code", rsp_code, 8'h00);
      check("rr_data", rsp_data, 8'h00);
      check("rr_cont_off", cont_active, 1'b0);
      nxt(1);
      reset_n = 1'b1;
      nxt(1);

      // fresh request after reset, and no leftover poll
      send(8'h01, 32'h0000_0011);
      nxt(1);
      check("fresh_en", sd_enable, 1'b1);
      check("fresh_req", sd_request, 8'h01);
      finish(8'h33);
      wait_rsp("fresh", 8'h01, 8'h33);
      accept;
      nxt(5);
      check("fresh_idle", sd_enable, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
